// File: rtl/refill_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : refill_pkg
//  Description : Shared types and constants for the refill port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package refill_pkg;

    function automatic int unsigned beats_for(input int unsigned word_offset);
        return 32'd1 << word_offset;
    endfunction

    localparam int unsigned WORD_OFFSET_DEFAULT = 2;
    localparam int unsigned BEATS               = beats_for(WORD_OFFSET_DEFAULT);

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/refill_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : refill_port_arbiter_if
//  Description : Cache-side and memory-side signals of the refill port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface refill_port_arbiter_if #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
);
    logic                   req_cc02arb;
    logic [ADR_WIDTH-1:0]   adr_cc02arb;
    logic                   req_cc12arb;
    logic [ADR_WIDTH-1:0]   adr_cc12arb;
    logic                   ack_arb2cc0;
    logic                   ack_arb2cc1;
    logic [DATA_WIDTH-1:0]  dat_arb2cc;
    logic [WORD_OFFSET-1:0] word_arb2cc;
    logic                   req_arb2mem;
    logic [ADR_WIDTH-1:0]   adr_arb2mem;
    logic                   ack_mem2arb;
    logic [DATA_WIDTH-1:0]  dat_mem2arb;
    logic                   owner_arb;
    logic                   err_arb;

    // master: the caches and the memory around the arbiter; slave: the arbiter
    modport master (
        output req_cc02arb, adr_cc02arb, req_cc12arb, adr_cc12arb,
        output ack_mem2arb, dat_mem2arb,
        input  ack_arb2cc0, ack_arb2cc1, dat_arb2cc, word_arb2cc,
        input  req_arb2mem, adr_arb2mem, owner_arb, err_arb
    );

    modport slave (
        input  req_cc02arb, adr_cc02arb, req_cc12arb, adr_cc12arb,
        input  ack_mem2arb, dat_mem2arb,
        output ack_arb2cc0, ack_arb2cc1, dat_arb2cc, word_arb2cc,
        output req_arb2mem, adr_arb2mem, owner_arb, err_arb
    );
endinterface
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin pick.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);
    assign gnt_valid = req0 | req1;
    // On a tie the requester that was not served last wins
    assign gnt_id    = (req0 & req1) ? ~last : req1;
endmodule
`default_nettype wire

// File: rtl/refill_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : refill_port_arbiter
//  Description : Shares the memory refill port between I-cache and D-cache,
//                one full line burst per grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_port_arbiter
    import refill_pkg::*;
#(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    refill_port_arbiter_if.slave bus
);
    localparam logic [WORD_OFFSET-1:0] c_last_beat =
        WORD_OFFSET'(beats_for(WORD_OFFSET) - 1);

    state_t                 state_q,   state_d;
    logic                   owner_q,   owner_d;
    logic                   last_q,    last_d;
    logic                   req_mem_q, req_mem_d;
    logic                   err_q,     err_d;
    logic                   abort_q,   abort_d;
    logic [WORD_OFFSET-1:0] beat_q,    beat_d;
    logic [ADR_WIDTH-1:0]   adr_q,     adr_d;

    logic                   w_gnt_valid;
    logic                   w_gnt_id;
    logic                   w_owner_req;
    logic                   w_fwd;
    logic [DATA_WIDTH-1:0]  w_dat;

    rr_pick2 u_pick (
        .req0      (bus.req_cc02arb),
        .req1      (bus.req_cc12arb),
        .last      (last_q),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    assign w_owner_req = (owner_q == REQ_DC) ? bus.req_cc12arb : bus.req_cc02arb;
    // Beats of an abandoned burst are still sunk but never reach a cache
    assign w_fwd = (state_q == BUSY) && bus.ack_mem2arb && w_owner_req && !abort_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        req_mem_d = req_mem_q;
        abort_d   = abort_q;
        beat_d    = beat_q;
        adr_d     = adr_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = bus.ack_mem2arb;
                if (w_gnt_valid) begin
                    owner_d   = w_gnt_id;
                    adr_d     = (w_gnt_id == REQ_DC) ? bus.adr_cc12arb : bus.adr_cc02arb;
                    req_mem_d = 1'b1;
                    beat_d    = '0;
                    abort_d   = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (!w_owner_req) begin
                    abort_d = 1'b1;
                end
                if (bus.ack_mem2arb) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == c_last_beat) begin
                        req_mem_d = 1'b0;
                        last_d    = owner_q;
                        state_d   = RELEASE;
                    end
                end
            end
            RELEASE: begin
                err_d   = bus.ack_mem2arb;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= REQ_IC;
            last_q    <= 1'b1;
            req_mem_q <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            beat_q    <= '0;
            adr_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            req_mem_q <= req_mem_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            beat_q    <= beat_d;
            adr_q     <= adr_d;
        end
    end

    assign w_dat           = bus.dat_mem2arb;
    assign bus.dat_arb2cc  = w_dat;
    assign bus.ack_arb2cc0 = w_fwd && (owner_q == REQ_IC);
    assign bus.ack_arb2cc1 = w_fwd && (owner_q == REQ_DC);
    assign bus.word_arb2cc = beat_q;
    assign bus.req_arb2mem = req_mem_q;
    assign bus.adr_arb2mem = adr_q;
    assign bus.owner_arb   = owner_q;
    assign bus.err_arb     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_refill_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_refill_port_arbiter
//  Description : Self-checking bench for refill_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_refill_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WO = 2;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    refill_port_arbiter_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO)) bus ();

    refill_port_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_OFFSET(WO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line-level reference: who owns the port, how many beats have been
    // delivered, and whether the one-cycle cool-down after a burst is running.
    bit          m_active, m_cool, m_abort, m_err, m_last, m_owner, m_just_done;
    int          m_beats;
    logic [31:0] m_adr;

    logic        s_ack0, s_ack1, s_req_mem, s_owner, s_err;
    logic [1:0]  s_word;
    logic [31:0] s_adr;

    bit          pend [2];
    logic [31:0] radr [2];

    function automatic void model_reset();
        m_active = 0; m_cool = 0; m_abort = 0; m_err = 0;
        m_last = 1; m_owner = 0; m_beats = 0; m_adr = '0; m_just_done = 0;
    endfunction

    task automatic step(input bit r0, input logic [AW-1:0] a0, input bit r1,
                        input logic [AW-1:0] a1, input bit ak, input logic [DW-1:0] d);
        bit own_req, e0, e1;
        @(negedge clk);
        bus.req_cc02arb = r0;
        bus.adr_cc02arb = a0;
        bus.req_cc12arb = r1;
        bus.adr_cc12arb = a1;
        bus.ack_mem2arb = ak;
        bus.dat_mem2arb = d;
        #1;
        own_req = m_owner ? r1 : r0;
        e0 = m_active && !m_owner && ak && own_req && !m_abort;
        e1 = m_active &&  m_owner && ak && own_req && !m_abort;
        s_ack0 = bus.ack_arb2cc0;  s_ack1 = bus.ack_arb2cc1;
        s_req_mem = bus.req_arb2mem; s_adr = bus.adr_arb2mem;
        s_owner = bus.owner_arb;   s_err = bus.err_arb;  s_word = bus.word_arb2cc;
        check("ack0", s_ack0, e0);
        check("ack1", s_ack1, e1);
        check("dat", bus.dat_arb2cc, d);
        check("word", s_word, m_beats % NB);
        check("req_mem", s_req_mem, m_active);
        check("adr_mem", s_adr, m_adr);
        check("owner", s_owner, m_owner);
        check("err", s_err, m_err);
        @(posedge clk);
        m_just_done = 0;
        m_err = ak && !m_active;
        if (m_active) begin
            if (!own_req) m_abort = 1;
            if (ak) begin
                m_beats++;
                if (m_beats == NB) begin
                    m_active = 0; m_cool = 1; m_last = m_owner; m_just_done = 1;
                end
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (r0 || r1) begin
            m_owner  = (r0 && r1) ? !m_last : r1;
            m_adr    = m_owner ? a1 : a0;
            m_active = 1; m_beats = 0; m_abort = 0;
        end
    endtask

    task automatic apply_reset();
        bus.req_cc02arb = 0; bus.adr_cc02arb = '0;
        bus.req_cc12arb = 0; bus.adr_cc12arb = '0;
        bus.ack_mem2arb = 0; bus.dat_mem2arb = '0;
        rst = 1'b0;
        #1;
        check("rst_req_mem", bus.req_arb2mem, 0);
        check("rst_adr_mem", bus.adr_arb2mem, 0);
        check("rst_owner", bus.owner_arb, 0);
        check("rst_err", bus.err_arb, 0);
        check("rst_word", bus.word_arb2cc, 0);
        check("rst_ack0", bus.ack_arb2cc0, 0);
        check("rst_ack1", bus.ack_arb2cc1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit ak;

        // Single requester
        apply_reset();
        step(1, 32'hFF07BD08, 0, '0, 0, '0);
        step(1, 32'hFF07BD08, 0, '0, 0, '0);
        check("single_req_mem", s_req_mem, 1);
        check("single_adr", s_adr, 32'hFF07BD08);
        for (int i = 0; i < NB; i++) begin
            step(1, 32'hFF07BD08, 0, '0, 1, 32'hFFFFFFFF);
            check("single_ack0", s_ack0, 1);
            check("single_ack1", s_ack1, 0);
            check("single_word", s_word, i);
        end
        step(0, 32'hFF07BD08, 0, '0, 0, '0);
        check("single_req_fall", s_req_mem, 0);
        step(0, '0, 0, '0, 0, '0);

        // Tie straight after reset
        apply_reset();
        step(1, 32'hA5552D0C, 1, 32'hD500AD00, 0, '0);
        for (int i = 0; i < NB; i++) begin
            step(1, 32'hA5552D0C, 1, 32'hD500AD00, 1, $urandom);
            if (i == 0) check("tie_owner0", s_owner, 0);
        end
        step(0, 32'hA5552D0C, 1, 32'hD500AD00, 0, '0);
        step(0, 32'hA5552D0C, 1, 32'hD500AD00, 0, '0);
        step(0, 32'hA5552D0C, 1, 32'hD500AD00, 0, '0);
        check("tie_owner1", s_owner, 1);
        check("tie_adr1", s_adr, 32'hD500AD00);
        for (int i = 0; i < NB; i++) step(0, '0, 1, 32'hD500AD00, 1, $urandom);
        step(0, '0, 0, '0, 0, '0);

        // Round robin over three back-to-back ties
        apply_reset();
        for (int b = 0; b < 3; b++) begin
            step(1, 32'h1000_0000, 1, 32'h2000_0000, 0, '0);
            cnt = 0;
            for (int i = 0; i < NB; i++) begin
                step(1, 32'h1000_0000, 1, 32'h2000_0000, 1, $urandom);
                cnt += s_ack0 + s_ack1;
                if (i == 0) check("rr_owner", s_owner, b % 2);
            end
            check("rr_fwd_count", cnt, 4);
            step((b % 2) == 1, 32'h1000_0000, (b % 2) == 0, 32'h2000_0000, 0, '0);
        end

        // Abort by requester 1 after beat 1
        apply_reset();
        step(0, '0, 1, 32'h0BAD_F00C, 0, '0);
        for (int i = 0; i < NB; i++) begin
            step(0, '0, i < 2, 32'h0BAD_F00C, 1, $urandom);
            check("abort_ack1", s_ack1, i < 2);
            check("abort_req_mem", s_req_mem, 1);
        end
        step(0, '0, 0, '0, 0, '0);
        check("abort_release", s_req_mem, 0);
        step(1, 32'h0000_4440, 0, '0, 0, '0);
        step(1, 32'h0000_4440, 0, '0, 1, $urandom);
        check("abort_next_ack0", s_ack0, 1);
        for (int i = 1; i < NB; i++) step(1, 32'h0000_4440, 0, '0, 1, $urandom);

        // Spurious memory ack in IDLE
        apply_reset();
        step(0, '0, 0, '0, 1, 32'h1234_5678);
        check("spur_ack0", s_ack0, 0);
        check("spur_ack1", s_ack1, 0);
        step(0, '0, 0, '0, 0, '0);
        check("spur_err_hi", s_err, 1);
        step(0, '0, 0, '0, 0, '0);
        check("spur_err_lo", s_err, 0);

        // Asynchronous reset mid-burst, then a fresh request
        apply_reset();
        step(1, 32'hCAFE_0040, 0, '0, 0, '0);
        step(1, 32'hCAFE_0040, 0, '0, 1, $urandom);
        step(1, 32'hCAFE_0040, 0, '0, 1, $urandom);
        #2;
        apply_reset();
        step(1, 32'hBEEF_0080, 0, '0, 0, '0);
        step(1, 32'hBEEF_0080, 0, '0, 1, $urandom);
        check("restart_ack0", s_ack0, 1);
        check("restart_word", s_word, 0);

        // Randomized traffic with aborts and stray acks
        apply_reset();
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if (m_active && m_owner == i[0] && m_beats >= 1 && $urandom_range(15) == 0)
                        pend[i] = 0;
                end else if (!(m_active && m_owner == i[0]) && !m_cool && $urandom_range(3) == 0) begin
                    pend[i] = 1;
                    radr[i] = $urandom;
                end
            end
            ak = m_active ? bit'($urandom_range(1)) : ($urandom_range(7) == 0);
            step(pend[0], radr[0], pend[1], radr[1], ak, $urandom);
            if (m_just_done) pend[m_last] = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
